// File: rtl/tick_timer_arbiter.sv
// tick_timer_arbiter: four requesters share one prescaled interval timer.
// Round-robin arbitration in IDLE; the winner owns the timer for dur*M+1
// cycles (RUN), then receives a one-cycle done pulse (DONE).
// Optional feature: define TIMER_ABORT_EN to add the abort input.
module tick_timer_arbiter #(
  parameter int M  = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    req,
  input  logic [4*DW-1:0] dur,
`ifdef TIMER_ABORT_EN
  input  logic          abort,
`endif
  output logic [3:0]    grant,
  output logic [3:0]    done,
  output logic          busy,
  output logic          tick
);

  localparam int PW = (M > 2) ? $clog2(M) : 1;
  localparam logic [PW-1:0] PMAX = PW'(M - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   presc;
  logic [DW-1:0]   count;
  logic [1:0]      ptr;
  logic [1:0]      owner;
  logic [1:0]      win;
  logic [1:0]      cand;
  logic            found;
  logic            abort_i;

`ifdef TIMER_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // Round-robin pick: first set request bit starting at ptr, wrapping mod 4.
  always_comb begin
    win   = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // Controller: arbitration, prescaled countdown and pointer rotation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      presc <= '0;
      count <= '0;
      ptr   <= '0;
      owner <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            count <= dur[int'(win)*DW +: DW];
            presc <= '0;
            owner <= win;
            state <= RUN;
          end
        end
        RUN: begin
          // Counter and prescaler freeze once the interval is over.
          if (abort_i || count == '0) begin
            state <= DONE;
          end else if (presc == PMAX) begin
            presc <= '0;
            count <= count - 1'b1;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        DONE: begin
          // Just-served requester drops to lowest priority.
          ptr   <= owner + 2'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state, so they are glitch-free
  // and one-hot by construction (owner is a single index).
  assign grant = (state == RUN)  ? (4'b0001 << owner) : 4'b0000;
  assign done  = (state == DONE) ? (4'b0001 << owner) : 4'b0000;
  assign busy  = (state == RUN) || (state == DONE);
  assign tick  = (state == RUN) && (count != '0) && (presc == PMAX);

endmodule

// File: doc/tick_timer_arbiter.md
TICK_TIMER_ARBITER -- requirements
Module: tick_timer_arbiter

Interface
REQ-001 Parameter M, default 10: prescaler modulus (clock cycles per tick), SHALL be >= 2.
REQ-002 Parameter DW, default 8: width of each requested duration, in ticks.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  4  per-requester request level; bit i belongs to requester i.
REQ-006 dur  input  4*DW  packed durations; requester i uses dur[i*DW +: DW].
REQ-007 grant  output  4  one-hot owner of the shared timer; all zero when not running.
REQ-008 done  output  4  one-cycle completion pulse to the granted requester.
REQ-009 busy  output  1  high while the state is RUN or DONE.
REQ-010 tick  output  1  high in RUN cycles where the prescaler equals M-1.
REQ-011 abort  input  1  cancels the running interval; present only when TIMER_ABORT_EN is defined.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 Internal state SHALL be: prescaler of clog2(M) bits, DW-bit remaining count, 2-bit round-robin pointer ptr, and 2-bit owner index.
REQ-014 IDLE, req==0: remain in IDLE; grant=0; done=0.
REQ-015 IDLE, req!=0: select the first set bit searching ptr, ptr+1, ... (mod 4), load count<=dur of winner, prescaler<=0, owner<=winner, go RUN.
REQ-016 RUN: grant = one-hot(owner); dur is sampled only at the IDLE->RUN edge, later changes SHALL be ignored.
REQ-017 RUN, count==0: go DONE; prescaler and count hold.
REQ-018 RUN, count!=0: prescaler increments; on prescaler==M-1, prescaler<=0 and count<=count-1.
REQ-019 RUN length SHALL be exactly dur*M+1 cycles; dur=0 gives a 1-cycle RUN.
REQ-020 DONE: done[owner]=1 for exactly one cycle, grant=0, ptr<=owner+1 (wrap 3->0), go IDLE.
REQ-021 Requesters SHALL drop req in the done cycle; if req[owner] is still high in IDLE, it is re-arbitrated at lowest priority.
REQ-022 Dropping req during RUN SHALL NOT cancel the interval.
REQ-023 A new or changed req while busy SHALL have no effect until the next IDLE cycle.
REQ-024 Simultaneous requests SHALL be served one at a time; no requester waits more than 3 intervals.
REQ-025 At most one bit of grant and of done SHALL be high in any cycle.

Reset
REQ-026 reset SHALL take precedence over all other inputs.
REQ-027 With reset high at a clock edge: state=IDLE, prescaler=0, count=0, ptr=0, owner=0.
REQ-028 Outputs after reset: grant=0, done=0, busy=0, tick=0.
REQ-029 Reset during RUN SHALL abandon the interval with no done pulse.

Configuration
REQ-030 Macro TIMER_ABORT_EN defined: abort port exists.
REQ-031 abort high in a RUN cycle SHALL force DONE on the next edge, giving the normal done pulse and ptr update.
REQ-032 abort SHALL be ignored in IDLE and DONE.
REQ-033 Macro TIMER_ABORT_EN undefined: no abort port, and intervals always run to completion.

Verification (M=4, DW=8)
REQ-034 Single request: reset, req=0001, dur0=3 -> grant=0001 for 13 cycles, tick high 3 times, done=0001 one cycle, then busy=0.
REQ-035 Zero duration: req=0100, dur2=0 -> grant=0100 for 1 cycle, next cycle done=0100.
REQ-036 Round-robin: req=1111 held, all dur=1 -> grant order 0001, 0010, 0100, 1000, 0001, each grant lasting 5 cycles.
REQ-037 Mid-run changes: req=0010, dur1=2; change dur1 to 9 and drop req during RUN -> RUN still lasts 9 cycles and done=0010.
REQ-038 Reset mid-run: reset asserted at RUN cycle 5 -> next cycle grant=0, busy=0, no done pulse, ptr=0.
REQ-039 Abort, TIMER_ABORT_EN defined: dur0=10, abort pulsed at RUN cycle 6 -> DONE on the next edge, done=0001, ptr=1.
